// File: rtl/snn_weight_mem_if.sv
// Command/response bundle for the synaptic weight store.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. Once cmd_valid is raised, the master keeps it
// and cmd_op/cmd_addr/cmd_data stable until that edge. cmd_ready does not
// depend on cmd_valid. rsp_valid is a one-cycle pulse with no back-pressure.
// rsp_data keeps its value until the next response.
interface snn_weight_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_sat;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_sat, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_sat, busy
  );
endinterface

// File: rtl/snn_weight_mem.sv
// Synaptic weight store made of flops. It handles read, write, a saturating
// reward update (read-modify-write with a signed delta) and a clear-all that
// walks every entry, one entry per cycle.
module snn_weight_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  snn_weight_mem_if.slave  cmd_if,
  output logic [1:0]       o_dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SUM_W = DATA_W + 2;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_UPDATE = 2'b10;

  // Clamp limits for the extended sum (DATA_W+2 bits, two's complement).
  localparam logic signed [SUM_W-1:0] SMAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SMIN = {3'b111, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UPD  = 2'd1,
    S_CLR  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0]        r_cnt;
  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_delta;
  logic [DATA_W-1:0]        r_old;
  logic                     r_rsp_valid;
  logic [DATA_W-1:0]        r_rsp_data;
  logic                     r_rsp_sat;

  logic                     w_accept;
  logic                     w_clr_last;
  logic signed [SUM_W-1:0]  w_old_ext;
  logic signed [SUM_W-1:0]  w_delta_ext;
  logic signed [SUM_W-1:0]  w_sum;
  logic [DATA_W-1:0]        w_upd_val;
  logic                     w_upd_sat;

  // Commands are taken only in IDLE. The ready term comes from the state alone.
  assign w_accept   = cmd_if.cmd_valid && (r_state == S_IDLE);
  assign w_clr_last = (r_cnt == ADDR_W'(DEPTH - 1));

  // State register. Reset returns to IDLE, which aborts any UPD or CLR in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: UPDATE takes one extra cycle, CLEAR takes DEPTH cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_if.cmd_op == OP_UPDATE) begin
            w_next = S_UPD;
          end else if (cmd_if.cmd_op == 2'b11) begin
            w_next = S_CLR;
          end
        end
      end
      S_UPD:   w_next = S_IDLE;
      S_CLR:   w_next = w_clr_last ? S_IDLE : S_CLR;
      default: w_next = S_IDLE;
    endcase
  end

  // Saturating add of the latched old value and delta. Two guard bits keep
  // the sum exact, so the clamp only has to look at the top bits.
  always_comb begin
    w_old_ext   = SIGNED ? {{2{r_old[DATA_W-1]}}, r_old} : {2'b00, r_old};
    w_delta_ext = {{2{r_delta[DATA_W-1]}}, r_delta};
    w_sum       = w_old_ext + w_delta_ext;
    w_upd_val   = w_sum[DATA_W-1:0];
    w_upd_sat   = 1'b0;
    if (SIGNED) begin
      if (w_sum > SMAX) begin
        w_upd_val = SMAX[DATA_W-1:0];
        w_upd_sat = 1'b1;
      end else if (w_sum < SMIN) begin
        w_upd_val = SMIN[DATA_W-1:0];
        w_upd_sat = 1'b1;
      end
    end else begin
      if (w_sum[SUM_W-1]) begin
        w_upd_val = '0;
        w_upd_sat = 1'b1;
      end else if (w_sum[DATA_W]) begin
        w_upd_val = '1;
        w_upd_sat = 1'b1;
      end
    end
  end

  // Array writes, operand latches and registered response.
  // The array is written on the accept edge, so a READ on the next edge
  // already sees the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_cnt       <= '0;
      r_addr      <= '0;
      r_delta     <= '0;
      r_old       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_sat   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (cmd_if.cmd_op)
              OP_READ: begin
                r_rsp_data  <= r_mem[cmd_if.cmd_addr];
                r_rsp_sat   <= 1'b0;
                r_rsp_valid <= 1'b1;
              end
              OP_WRITE: begin
                r_mem[cmd_if.cmd_addr] <= cmd_if.cmd_data;
                r_rsp_data  <= cmd_if.cmd_data;
                r_rsp_sat   <= 1'b0;
                r_rsp_valid <= 1'b1;
              end
              OP_UPDATE: begin
                r_addr  <= cmd_if.cmd_addr;
                r_delta <= cmd_if.cmd_data;
                r_old   <= r_mem[cmd_if.cmd_addr];
              end
              default: begin
                r_cnt <= '0;
              end
            endcase
          end
        end
        S_UPD: begin
          r_mem[r_addr] <= w_upd_val;
          r_rsp_data    <= w_upd_val;
          r_rsp_sat     <= w_upd_sat;
          r_rsp_valid   <= 1'b1;
        end
        S_CLR: begin
          r_mem[r_cnt] <= '0;
          r_cnt        <= r_cnt + 1'b1;
          if (w_clr_last) begin
            r_rsp_data  <= '0;
            r_rsp_sat   <= 1'b0;
            r_rsp_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_if.cmd_ready = (r_state == S_IDLE);
  assign cmd_if.busy      = (r_state != S_IDLE);
  assign cmd_if.rsp_valid = r_rsp_valid;
  assign cmd_if.rsp_data  = r_rsp_data;
  assign cmd_if.rsp_sat   = r_rsp_sat;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_snn_weight_mem.sv
// Bench for snn_weight_mem. An unsigned instance and a signed instance get
// the same command stream. A reference model predicts the response data,
// saturation flag, response cycle and the cycles where cmd_ready is low.
module tb_snn_weight_mem;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_UP = 2'b10;
  localparam logic [1:0] OP_CL = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             c_valid = 1'b0;
  logic [1:0]       c_op    = 2'b00;
  logic [3:0]       c_addr  = 4'd0;
  logic [7:0]       c_data  = 8'd0;
  logic [1:0]       dbg_u;
  logic [1:0]       dbg_s;

  snn_weight_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bu ();
  snn_weight_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bs ();

  assign bu.cmd_valid = c_valid;
  assign bu.cmd_op    = c_op;
  assign bu.cmd_addr  = c_addr;
  assign bu.cmd_data  = c_data;
  assign bs.cmd_valid = c_valid;
  assign bs.cmd_op    = c_op;
  assign bs.cmd_addr  = c_addr;
  assign bs.cmd_data  = c_data;

  snn_weight_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .cmd_if(bu.slave), .o_dbg_state(dbg_u));
  snn_weight_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .cmd_if(bs.slave), .o_dbg_state(dbg_s));

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    int         cyc;
    logic [7:0] du;
    logic       su;
    logic [7:0] ds;
    logic       ss;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] eu;
    logic       su;
    logic [7:0] es;
    logic       ss;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] mu [DEPTH];
  logic [7:0] ms [DEPTH];
  int         cyc     = 0;
  int         busy_lo = 1;
  int         busy_hi = 0;
  int         n_chk   = 0;
  int         n_fail  = 0;
  bit         mon_en  = 1'b0;
  vec_t       tab [18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Saturating add done with plain integer arithmetic and explicit range limits.
  function automatic void model_upd(input logic [7:0] old, input logic [7:0] d, input bit sgn,
                                    output logic [7:0] res, output logic sat);
    int o;
    int s;
    int lo;
    int hi;
    o   = sgn ? int'($signed(old)) : int'(old);
    s   = o + int'($signed(d));
    lo  = sgn ? -128 : 0;
    hi  = sgn ? 127 : 255;
    sat = 1'b0;
    if (s < lo) begin
      s = lo; sat = 1'b1;
    end else if (s > hi) begin
      s = hi; sat = 1'b1;
    end
    res = 8'(s);
  endfunction

  task automatic model_flush();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      mu[i] = 8'h00;
      ms[i] = 8'h00;
    end
    busy_lo = 1;
    busy_hi = 0;
  endtask

  // ---------------- response / ready monitor ----------------
  task automatic monitor_step();
    bit   want;
    bit   exp_rdy;
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_missing: no response seen, expected at cycle %0d (now %0d)", exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    want = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    check("rsp_valid_u", 32'(bu.rsp_valid), 32'(want));
    check("rsp_valid_s", 32'(bs.rsp_valid), 32'(want));
    if (want) begin
      e = exp_q.pop_front();
      check("rsp_data_u", 32'(bu.rsp_data), 32'(e.du));
      check("rsp_sat_u",  32'(bu.rsp_sat),  32'(e.su));
      check("rsp_data_s", 32'(bs.rsp_data), 32'(e.ds));
      check("rsp_sat_s",  32'(bs.rsp_sat),  32'(e.ss));
    end
    exp_rdy = !(cyc >= busy_lo && cyc <= busy_hi);
    check("cmd_ready_u", 32'(bu.cmd_ready), 32'(exp_rdy));
    check("cmd_ready_s", 32'(bs.cmd_ready), 32'(exp_rdy));
    check("busy_u",      32'(bu.busy),      32'(!exp_rdy));
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (mon_en) monitor_step();
  end

  // ---------------- driver tasks ----------------
  // Enter and leave 1 time unit after a rising edge. Valid stays up until
  // the accepting edge.
  task automatic send(input vec_t v, input bit use_tab, output int acc);
    int   n;
    int   lat;
    exp_t e;
    n       = 0;
    c_valid = 1'b1;
    c_op    = v.op;
    c_addr  = v.addr;
    c_data  = v.data;
    @(negedge clk);
    while (!bu.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: cmd_ready low for 200 cycles, op %0d", v.op);
      c_valid = 1'b0;
      acc = 0;
      @(posedge clk);
      #1;
      return;
    end
    acc  = cyc + 1;
    e    = '0;
    lat  = 1;
    case (v.op)
      OP_RD: begin
        e.du = mu[v.addr];
        e.ds = ms[v.addr];
      end
      OP_WR: begin
        mu[v.addr] = v.data;
        ms[v.addr] = v.data;
        e.du = v.data;
        e.ds = v.data;
      end
      OP_UP: begin
        model_upd(mu[v.addr], v.data, 1'b0, e.du, e.su);
        model_upd(ms[v.addr], v.data, 1'b1, e.ds, e.ss);
        mu[v.addr] = e.du;
        ms[v.addr] = e.ds;
        lat     = 2;
        busy_lo = acc;
        busy_hi = acc;
      end
      default: begin
        for (int i = 0; i < DEPTH; i++) begin
          mu[i] = 8'h00;
          ms[i] = 8'h00;
        end
        lat     = DEPTH + 1;
        busy_lo = acc;
        busy_hi = acc + DEPTH - 1;
      end
    endcase
    if (use_tab) begin
      e.du = v.eu; e.su = v.su; e.ds = v.es; e.ss = v.ss;
    end
    e.cyc = acc + lat - 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    c_valid = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data);
    vec_t v;
    int   acc;
    v = '{op, addr, data, 8'h00, 1'b0, 8'h00, 1'b0};
    send(v, 1'b0, acc);
  endtask

  task automatic idle(input int n);
    c_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    c_valid = 1'b0;
    rst     = 1'b1;
    repeat (n) @(posedge clk);
    model_flush();
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_ready_u"}, 32'(bu.cmd_ready), 32'd1);
    check({tag, "_ready_s"}, 32'(bs.cmd_ready), 32'd1);
    check({tag, "_valid_u"}, 32'(bu.rsp_valid), 32'd0);
    check({tag, "_data_u"},  32'(bu.rsp_data),  32'd0);
    check({tag, "_data_s"},  32'(bs.rsp_data),  32'd0);
    check({tag, "_sat_s"},   32'(bs.rsp_sat),   32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acc_cl;
    int acc_rd;
    vec_t v;

    tab[0]  = '{OP_RD, 4'd5,  8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tab[1]  = '{OP_WR, 4'd3,  8'hA5, 8'hA5, 1'b0, 8'hA5, 1'b0};
    tab[2]  = '{OP_RD, 4'd3,  8'h00, 8'hA5, 1'b0, 8'hA5, 1'b0};
    tab[3]  = '{OP_WR, 4'd7,  8'hF0, 8'hF0, 1'b0, 8'hF0, 1'b0};
    tab[4]  = '{OP_UP, 4'd7,  8'h20, 8'hFF, 1'b1, 8'h10, 1'b0};
    tab[5]  = '{OP_UP, 4'd7,  8'h80, 8'h7F, 1'b0, 8'h90, 1'b0};
    tab[6]  = '{OP_UP, 4'd7,  8'h80, 8'h00, 1'b1, 8'h80, 1'b1};
    tab[7]  = '{OP_WR, 4'd8,  8'h7E, 8'h7E, 1'b0, 8'h7E, 1'b0};
    tab[8]  = '{OP_UP, 4'd8,  8'h05, 8'h83, 1'b0, 8'h7F, 1'b1};
    tab[9]  = '{OP_WR, 4'd9,  8'h81, 8'h81, 1'b0, 8'h81, 1'b0};
    tab[10] = '{OP_UP, 4'd9,  8'hFB, 8'h7C, 1'b0, 8'h80, 1'b1};
    tab[11] = '{OP_WR, 4'd10, 8'h10, 8'h10, 1'b0, 8'h10, 1'b0};
    tab[12] = '{OP_UP, 4'd10, 8'hF0, 8'h00, 1'b0, 8'h00, 1'b0};
    tab[13] = '{OP_RD, 4'd7,  8'h00, 8'h00, 1'b0, 8'h80, 1'b0};
    tab[14] = '{OP_WR, 4'd11, 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0};
    tab[15] = '{OP_UP, 4'd11, 8'h7F, 8'hFF, 1'b1, 8'h7E, 1'b0};
    tab[16] = '{OP_UP, 4'd11, 8'h01, 8'hFF, 1'b1, 8'h7F, 1'b0};
    tab[17] = '{OP_RD, 4'd8,  8'h00, 8'h83, 1'b0, 8'h7F, 1'b0};

    // Reset, then check the idle outputs.
    model_flush();
    @(posedge clk);
    #1;
    do_reset(2);
    mon_en = 1'b1;
    check_reset_outputs("reset");

    // Table vectors, sent back-to-back.
    for (int i = 0; i < 18; i++) begin
      send(tab[i], 1'b1, acc_rd);
    end
    idle(3);

    // CLEAR with a READ held on the port while the clear runs.
    for (int a = 0; a < DEPTH; a++) cmd(OP_WR, 4'(a), 8'h55);
    v = '{OP_CL, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    send(v, 1'b0, acc_cl);
    v = '{OP_RD, 4'd2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    send(v, 1'b0, acc_rd);
    check("held_read_accept_delay", 32'(acc_rd - acc_cl), 32'(DEPTH + 1));
    for (int a = 0; a < DEPTH; a++) cmd(OP_RD, 4'(a), 8'h00);
    idle(3);

    // Random commands with random idle gaps.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] op;
      r  = $urandom_range(0, 19);
      op = (r == 0) ? OP_CL : (r < 8) ? OP_RD : (r < 14) ? OP_WR : OP_UP;
      cmd(op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(DEPTH + 4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset during the UPD cycle: no response, and the entry is cleared.
    cmd(OP_WR, 4'd4, 8'h33);
    cmd(OP_UP, 4'd4, 8'h01);
    do_reset(1);
    check_reset_outputs("rst_upd");
    cmd(OP_RD, 4'd4, 8'h00);
    idle(2);

    // Reset at clear count 8: no response, every entry reads zero.
    for (int a = 0; a < DEPTH; a++) cmd(OP_WR, 4'(a), 8'h55);
    cmd(OP_CL, 4'd0, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    do_reset(1);
    check_reset_outputs("rst_clr");
    for (int a = 0; a < DEPTH; a++) cmd(OP_RD, 4'(a), 8'h00);
    idle(4);
    check("final_scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/snn_weight_mem.md
# snn_weight_mem

Parametrised synaptic weight store for the spiking-neural-network datapath, the successor of the fixed 16×8 register-file weight memory. It holds `DEPTH` weights of `DATA_W` bits and serves a single valid/ready command port. Supported commands are read, write, reward-modulated update (saturating read-modify-write with a signed delta) and a sequenced clear-all. It sits between the host/config interface and the neuron update logic, which issues reward updates after each learning episode.

## Interface
- `DATA_W`, default 8: weight width in bits.
- `ADDR_W`, default 4: address width; `DEPTH = 2**ADDR_W` entries.
- `SIGNED`, default 0: 0 = unsigned weights (range 0..2^DATA_W−1); 1 = two's-complement weights.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `cmd_valid`  in  1  — command present.
- `cmd_ready`  out  1  — block can accept a command.
- `cmd_op`  in  2  — 00 READ, 01 WRITE, 10 UPDATE, 11 CLEAR.
- `cmd_addr`  in  ADDR_W  — entry address (ignored for CLEAR).
- `cmd_data`  in  DATA_W  — write data (WRITE) or signed two's-complement delta (UPDATE).
- `rsp_valid`  out  1  — one-cycle response pulse.
- `rsp_data`  out  DATA_W  — response value; holds until the next response.
- `rsp_sat`  out  1  — saturation occurred; qualified by `rsp_valid`.
- `busy`  out  1  — multi-cycle operation in progress (equals `!cmd_ready`).

## Operation
- A command is accepted on an edge where `cmd_valid && cmd_ready`. The accepting edge is called E0.
- FSM states:
  - IDLE: `cmd_ready`=1.
  - UPD: one cycle, `cmd_ready`=0.
  - CLR: DEPTH cycles, `cmd_ready`=0.
- READ, accepted in IDLE:
  - `rsp_data` ← mem[addr] at E0, `rsp_valid`=1 in the following cycle.
  - Stays in IDLE, so back-to-back commands are allowed.
- WRITE, accepted in IDLE:
  - mem[addr] ← `cmd_data` at E0.
  - `rsp_data` ← `cmd_data` (echo); `rsp_valid` next cycle.
  - Stays in IDLE.
- UPDATE:
  - At E0: latch addr, delta and old = mem[addr]; go to UPD.
  - At E1: mem[addr] ← sat(old + delta), `rsp_data` ← same value, `rsp_sat` set per clamp, `rsp_valid` pulses in the cycle after E1; return to IDLE.
- Update arithmetic:
  - Sign-extend the delta, and zero- or sign-extend old per `SIGNED`, to DATA_W+2 bits, then add.
  - Unsigned: sum<0 → 0; sum>2^DATA_W−1 → 2^DATA_W−1.
  - Signed: clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - `rsp_sat`=1 only when the clamp changed the value.
- CLEAR:
  - At E0: counter ← 0; go to CLR.
  - Each CLR cycle: mem[counter] ← 0, counter+1.
  - After the write at count DEPTH−1: return to IDLE, `rsp_valid` pulses with `rsp_data`=0, `rsp_sat`=0.
- `rsp_sat`=0 for READ, WRITE and CLEAR responses.
- `cmd_valid` asserted while busy is not accepted. The command must be held (standard valid/ready); it is not dropped silently.
- Read-after-write hazard: a READ accepted the cycle after a WRITE or UPDATE to the same address returns the new value, because the array is updated before the next accept edge.
- Reset (`rst`=1 on an edge):
  - All mem entries ← 0.
  - State ← IDLE, counter ← 0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_sat`=0.
  - `cmd_ready`=1 in the cycle after reset deasserts.
- Reset during UPD or CLR aborts the operation and no response is issued. Reset has priority over any accept on the same edge.

## Timing
- READ / WRITE: 1-cycle latency to `rsp_valid`; throughput 1 command/cycle.
- UPDATE: 2-cycle latency; `cmd_ready` is low for exactly 1 cycle. The next command can be accepted in the same cycle `rsp_valid` is high.
- CLEAR: `cmd_ready` is low for exactly DEPTH cycles; `rsp_valid` arrives DEPTH+1 cycles after E0.
- All outputs are registered or decode state directly; there is no combinational path from `cmd_*` to any output.
- Storage is flops (reset-clearable); no SRAM macro.

## Test plan
- Reset, then READ addr 5 → `rsp_valid` one cycle later with `rsp_data`=0x00, `rsp_sat`=0.
- WRITE addr 3 = 0xA5, then READ addr 3 on the very next cycle → WRITE response 0xA5 (echo), READ response 0xA5; `cmd_ready` stays 1 throughout.
- UPDATE saturation, unsigned (SIGNED=0): WRITE addr 7 = 0xF0, then:
  - UPDATE +0x20 → 0xFF, sat=1.
  - UPDATE 0x80 (−128) → 0x7F, sat=0.
  - UPDATE −128 → 0x00, sat=1.
  - Each update: `cmd_ready` low 1 cycle, response 2 cycles after accept.
- UPDATE saturation, signed (SIGNED=1): WRITE 0x7E, UPDATE +5 → 0x7F, sat=1. WRITE 0x81, UPDATE 0xFB (−5) → 0x80, sat=1. WRITE 0x10, UPDATE 0xF0 → 0x00, sat=0.
- CLEAR with DEPTH=16:
  - Fill all entries with 0x55, issue CLEAR while holding a READ on `cmd_valid`.
  - Expect `cmd_ready` low for 16 cycles and the CLEAR response (0x00) 17 cycles after accept.
  - The held READ is then accepted and returns 0x00; a readback of all entries returns 0x00.
- Reset mid-operation:
  - Assert `rst` during the UPD cycle → no `rsp_valid`, target entry reads 0x00 afterwards.
  - Assert `rst` at CLR count 8 → no response, all entries 0, `cmd_ready`=1 after reset.
